// File: rtl/rr_decode_arbiter_if.sv
// Request/grant bundle between eight requesters and the round-robin decode arbiter.
// The arbiter uses the slave modport; requesters (or a bench) use master.
interface rr_decode_arbiter_if;
  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  logic [N_REQ-1:0] req;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_en;
  logic [N_REQ-1:0] gnt;
  logic             busy;
  logic             timeout;

  modport master (output req, input gnt_idx, gnt_en, gnt, busy, timeout);
  modport slave  (input req, output gnt_idx, gnt_en, gnt, busy, timeout);
endinterface

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter sharing one 3-to-8 decode resource among 8 requesters,
// with a mandatory dead cycle between grants. Optional hold timeout: RR_DECODE_TIMEOUT_EN.
module rr_decode_arbiter #(
  parameter int unsigned HOLD_MAX = 15,
  parameter int unsigned CNT_W    = 8
) (
  input logic               clk,
  input logic               rst_n,
  rr_decode_arbiter_if.slave bus
);
  localparam int unsigned     N_REQ    = 8;
  localparam int unsigned     IDX_W    = 3;
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  state_e             state_q,    state_d;
  logic [IDX_W-1:0]   last_ptr_q, last_ptr_d;
  logic [IDX_W-1:0]   gnt_idx_q,  gnt_idx_d;
  logic               gnt_en_q,   gnt_en_d;
  logic [N_REQ-1:0]   gnt_q,      gnt_d;
  logic               busy_q,     busy_d;
  logic               timeout_q,  timeout_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;

  logic               win_vld_c;
  logic [IDX_W-1:0]   win_idx_c;
  logic [CNT_W-1:0]   hold_inc_c;

  // First pending request scanning upward from last_ptr+1, wrapping modulo 8.
  always_comb begin
    logic [IDX_W-1:0] cand;
    win_vld_c = 1'b0;
    win_idx_c = '0;
    cand      = '0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      cand = last_ptr_q + IDX_W'(off);
      if (!win_vld_c && bus.req[cand]) begin
        win_vld_c = 1'b1;
        win_idx_c = cand;
      end
    end
  end

  // Saturating hold counter increment.
  always_comb begin
    hold_inc_c = (hold_cnt_q >= HOLD_LIM) ? hold_cnt_q : hold_cnt_q + CNT_W'(1);
  end

  always_comb begin
    state_d    = state_q;
    last_ptr_d = last_ptr_q;
    gnt_idx_d  = gnt_idx_q;
    gnt_en_d   = gnt_en_q;
    gnt_d      = gnt_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;

    unique case (state_q)
      S_IDLE, S_GAP: begin
        if (win_vld_c) begin
          state_d    = S_GRANT;
          gnt_idx_d  = win_idx_c;
          gnt_en_d   = 1'b1;
          gnt_d      = N_REQ'(1) << win_idx_c;
          last_ptr_d = win_idx_c;
          hold_cnt_d = CNT_W'(1);
        end else begin
          state_d  = S_IDLE;
          gnt_en_d = 1'b0;
          gnt_d    = '0;
        end
      end

      S_GRANT: begin
        if (!bus.req[gnt_idx_q]) begin
          state_d  = S_GAP;
          gnt_en_d = 1'b0;
          gnt_d    = '0;
`ifdef RR_DECODE_TIMEOUT_EN
        end else if (hold_cnt_q == HOLD_LIM) begin
          // Forced release; last_ptr already points here so this requester ranks last.
          state_d   = S_GAP;
          gnt_en_d  = 1'b0;
          gnt_d     = '0;
          timeout_d = 1'b1;
`endif
        end else begin
          hold_cnt_d = hold_inc_c;
        end
      end

      default: begin
        state_d  = S_IDLE;
        gnt_en_d = 1'b0;
        gnt_d    = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      last_ptr_q <= IDX_W'(N_REQ - 1);
      gnt_idx_q  <= '0;
      gnt_en_q   <= 1'b0;
      gnt_q      <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_ptr_q <= last_ptr_d;
      gnt_idx_q  <= gnt_idx_d;
      gnt_en_q   <= gnt_en_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign bus.gnt_idx = gnt_idx_q;
  assign bus.gnt_en  = gnt_en_q;
  assign bus.gnt     = gnt_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;

  // Grant vector must always be the gated decode of the index.
  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
  a_gnt_decode  : assert property (@(posedge clk) disable iff (!rst_n)
                    gnt_q == (gnt_en_q ? (N_REQ'(1) << gnt_idx_q) : N_REQ'(0)));
endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Directed self-checking bench for rr_decode_arbiter; covers the timeout
// scenario when RR_DECODE_TIMEOUT_EN is defined, long holds otherwise.
module tb_rr_decode_arbiter;
`ifdef RR_DECODE_TIMEOUT_EN
  localparam int unsigned HOLD = 4;
`else
  localparam int unsigned HOLD = 15;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  rr_decode_arbiter_if bus();

  rr_decode_arbiter #(.HOLD_MAX(HOLD), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bus.req = 8'h00;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    bus.req = 8'h00;
    step();
    n_cmp++; if (bus.gnt_en !== 1'b0) begin n_err++; $display("FAIL rst_gnt_en: got %b expected 0", bus.gnt_en); end
    n_cmp++; if (bus.gnt !== 8'h00) begin n_err++; $display("FAIL rst_gnt: got %h expected 00", bus.gnt); end
    n_cmp++; if (bus.gnt_idx !== 3'd0) begin n_err++; $display("FAIL rst_gnt_idx: got %0d expected 0", bus.gnt_idx); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.timeout !== 1'b0) begin n_err++; $display("FAIL rst_timeout: got %b expected 0", bus.timeout); end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if ({bus.gnt_en, bus.gnt, bus.busy} !== 10'b0) begin
        n_err++;
        $display("FAIL idle_quiet cyc%0d: got en=%b gnt=%h busy=%b expected 0/00/0", i, bus.gnt_en, bus.gnt, bus.busy);
      end
    end
  endtask

  task automatic test_two_req();
    do_reset();
    bus.req = 8'h24;
    step();
    n_cmp++; if ({bus.gnt_en, bus.gnt, bus.gnt_idx} !== {1'b1, 8'h04, 3'd2}) begin n_err++; $display("FAIL two_first: got en=%b gnt=%h idx=%0d expected 1/04/2", bus.gnt_en, bus.gnt, bus.gnt_idx); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL two_busy: got %b expected 1", bus.busy); end
    bus.req = 8'h20;
    step();
    n_cmp++; if ({bus.gnt_en, bus.gnt, bus.gnt_idx, bus.busy} !== {1'b0, 8'h00, 3'd2, 1'b1}) begin n_err++; $display("FAIL two_gap: got en=%b gnt=%h idx=%0d busy=%b expected 0/00/2/1", bus.gnt_en, bus.gnt, bus.gnt_idx, bus.busy); end
    step();
    n_cmp++; if ({bus.gnt_en, bus.gnt, bus.gnt_idx} !== {1'b1, 8'h20, 3'd5}) begin n_err++; $display("FAIL two_second: got en=%b gnt=%h idx=%0d expected 1/20/5", bus.gnt_en, bus.gnt, bus.gnt_idx); end
    bus.req = 8'h00;
    step();
    n_cmp++; if ({bus.gnt_en, bus.busy} !== 2'b01) begin n_err++; $display("FAIL two_gap2: got en=%b busy=%b expected 0/1", bus.gnt_en, bus.busy); end
    step();
    n_cmp++; if ({bus.gnt_en, bus.busy} !== 2'b00) begin n_err++; $display("FAIL two_idle: got en=%b busy=%b expected 0/0", bus.gnt_en, bus.busy); end
  endtask

  task automatic test_fairness();
    logic [7:0] oh;
    logic [2:0] ix;
    do_reset();
    bus.req = 8'hFF;
    for (int e = 0; e < 9; e++) begin
      ix = 3'(e % 8);
      oh = 8'h01 << ix;
      step();
      n_cmp++; if ({bus.gnt_en, bus.gnt, bus.gnt_idx} !== {1'b1, oh, ix}) begin n_err++; $display("FAIL rr_grant%0d: got en=%b gnt=%h idx=%0d expected 1/%h/%0d", e, bus.gnt_en, bus.gnt, bus.gnt_idx, oh, ix); end
      step();
      n_cmp++; if (bus.gnt !== oh) begin n_err++; $display("FAIL rr_hold%0d: got %h expected %h", e, bus.gnt, oh); end
      bus.req = 8'hFF & ~oh;
      step();
      n_cmp++; if ({bus.gnt_en, bus.gnt} !== 9'b0) begin n_err++; $display("FAIL rr_gap%0d: got en=%b gnt=%h expected 0/00", e, bus.gnt_en, bus.gnt); end
      bus.req = 8'hFF;
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    bus.req = 8'h09;
    step();
    n_cmp++; if ({bus.gnt_en, bus.gnt, bus.gnt_idx} !== {1'b1, 8'h01, 3'd0}) begin n_err++; $display("FAIL mid_pre: got en=%b gnt=%h idx=%0d expected 1/01/0", bus.gnt_en, bus.gnt, bus.gnt_idx); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({bus.gnt_en, bus.gnt} !== 9'b0) begin n_err++; $display("FAIL mid_async: got en=%b gnt=%h expected 0/00", bus.gnt_en, bus.gnt); end
    step();
    rst_n = 1'b1;
    step();
    n_cmp++; if ({bus.gnt_en, bus.gnt, bus.gnt_idx} !== {1'b1, 8'h01, 3'd0}) begin n_err++; $display("FAIL mid_after: got en=%b gnt=%h idx=%0d expected 1/01/0", bus.gnt_en, bus.gnt, bus.gnt_idx); end
  endtask

  task automatic test_no_preempt();
    logic [7:0] pats [3];
    pats = '{8'hF7, 8'h01, 8'h80};
    do_reset();
    bus.req = 8'h08;
    step();
    n_cmp++; if ({bus.gnt, bus.gnt_idx} !== {8'h08, 3'd3}) begin n_err++; $display("FAIL np_grant: got gnt=%h idx=%0d expected 08/3", bus.gnt, bus.gnt_idx); end
    foreach (pats[i]) begin
      bus.req = 8'h08 | pats[i];
      step();
      n_cmp++; if (bus.gnt !== 8'h08) begin n_err++; $display("FAIL np_hold%0d: got %h expected 08", i, bus.gnt); end
    end
    bus.req = 8'h45;
    step();
    n_cmp++; if ({bus.gnt_en, bus.gnt, bus.gnt_idx} !== {1'b0, 8'h00, 3'd3}) begin n_err++; $display("FAIL np_gap: got en=%b gnt=%h idx=%0d expected 0/00/3", bus.gnt_en, bus.gnt, bus.gnt_idx); end
    step();
    n_cmp++; if ({bus.gnt, bus.gnt_idx} !== {8'h40, 3'd6}) begin n_err++; $display("FAIL np_next: got gnt=%h idx=%0d expected 40/6", bus.gnt, bus.gnt_idx); end
    bus.req = 8'h05;
    step();
    step();
    n_cmp++; if ({bus.gnt, bus.gnt_idx} !== {8'h01, 3'd0}) begin n_err++; $display("FAIL np_wrap: got gnt=%h idx=%0d expected 01/0", bus.gnt, bus.gnt_idx); end
  endtask

`ifdef RR_DECODE_TIMEOUT_EN
  task automatic test_timeout();
    int n_gnt = 0;
    int n_to  = 0;
    do_reset();
    bus.req = 8'h01;
    for (int r = 0; r < 3; r++) begin
      step();
      n_cmp++; if ({bus.gnt_en, bus.gnt, bus.timeout} !== {1'b1, 8'h01, 1'b0}) begin n_err++; $display("FAIL to_grant%0d: got en=%b gnt=%h to=%b expected 1/01/0", r, bus.gnt_en, bus.gnt, bus.timeout); end
      if (bus.gnt_en) n_gnt++;
      for (int c = 0; c < 3; c++) begin
        step();
        n_cmp++; if ({bus.gnt_en, bus.timeout} !== 2'b10) begin n_err++; $display("FAIL to_hold%0d_%0d: got en=%b to=%b expected 1/0", r, c, bus.gnt_en, bus.timeout); end
      end
      step();
      n_cmp++; if ({bus.gnt_en, bus.timeout, bus.busy} !== 3'b011) begin n_err++; $display("FAIL to_pulse%0d: got en=%b to=%b busy=%b expected 0/1/1", r, bus.gnt_en, bus.timeout, bus.busy); end
      if (bus.timeout) n_to++;
    end
    n_cmp++; if (n_gnt !== 3 || n_to !== 3) begin n_err++; $display("FAIL to_count: got grants=%0d timeouts=%0d expected 3/3", n_gnt, n_to); end
  endtask
`else
  task automatic test_long_hold();
    do_reset();
    bus.req = 8'h01;
    for (int c = 0; c < 40; c++) begin
      step();
      n_cmp++; if ({bus.gnt_en, bus.gnt, bus.timeout} !== {1'b1, 8'h01, 1'b0}) begin n_err++; $display("FAIL long_hold%0d: got en=%b gnt=%h to=%b expected 1/01/0", c, bus.gnt_en, bus.gnt, bus.timeout); end
    end
  endtask
`endif

  initial begin
    rst_n   = 1'b0;
    bus.req = 8'h00;
    test_reset();
    test_two_req();
    test_fairness();
    test_reset_mid_grant();
    test_no_preempt();
`ifdef RR_DECODE_TIMEOUT_EN
    test_timeout();
`else
    test_long_hold();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
